gsau_issue_ctrl: RTL

Parametrised issue/retire controller for the GSAU systolic array; successor to the first-generation GSAU control unit. Accepts paired scoreboard instructions and veggie-file operands, sequences a multi-row weight load before any activations are issued, and tracks in-flight destination tags in order. Retires array results through a registered, backpressured writeback port. Sits between scoreboard/veggie file upstream and the systolic array plus WB buffer downstream.

---
 rtl/sys_arr_pkg.sv | 13 +
 rtl/sync_fifo.sv | 37 +++
 rtl/gsau_issue_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sys_arr_pkg.sv
// Shared types and default geometry for the GSAU systolic-array control slice.
package sys_arr_pkg;

  localparam int GSAU_LANES  = 16;
  localparam int GSAU_ELEM_W = 32;

  typedef enum logic [1:0] {
    W_IDLE,
    W_LOAD,
    W_READY
  } gsau_wstate_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data; occupancy is tracked by the user.
module sync_fifo #(
  parameter int FIFODEPTH = 32,
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 wen,
  input  logic                 ren,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] rdata
);

  localparam int AW = $clog2(FIFODEPTH);

  logic [DATAWIDTH-1:0] mem [FIFODEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wen) wptr <= wptr + 1'b1;
      if (ren) rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wen) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/gsau_issue_ctrl.sv
// GSAU issue/retire controller: weight-load sequencing, in-order tag tracking, registered writeback.
// Optional performance counters are enabled by defining GSAU_PERF_CNT_EN.
module gsau_issue_ctrl
  import sys_arr_pkg::*;
#(
  parameter  int VEGGIEREGS = 256,
  parameter  int LANES      = GSAU_LANES,
  parameter  int ELEM_W     = GSAU_ELEM_W,
  parameter  int TAG_DEPTH  = 32,
  parameter  int ARRAY_ROWS = 16,
  localparam int TAG_W      = $clog2(VEGGIEREGS),
  localparam int VW         = LANES * ELEM_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             sb_valid,
  output logic             sb_ready,
  input  logic [TAG_W-1:0] sb_vdst,
  input  logic             sb_weight,
  input  logic             veg_valid,
  output logic             veg_ready,
  input  logic [VW-1:0]    veg_vs1,
  input  logic [VW-1:0]    veg_vs2,
  output logic [VW-1:0]    sa_array_in,
  output logic [VW-1:0]    sa_array_in_partials,
  output logic             sa_weight_en,
  output logic             sa_input_en,
  output logic             sa_partial_en,
  input  logic             sa_fifo_has_space,
  input  logic             sa_out_valid,
  output logic             sa_output_ready,
  input  logic [VW-1:0]    sa_array_output,
  output logic             wb_valid,
  input  logic             wb_output_ready,
  output logic [VW-1:0]    wb_psum,
  output logic [TAG_W-1:0] wb_wbdst,
  output logic             weights_loaded,
  output logic             busy,
`ifdef GSAU_PERF_CNT_EN
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_stall_cnt,
`endif
  output logic             tag_underflow
);

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
  localparam int RC_W  = $clog2(ARRAY_ROWS + 1);

  gsau_wstate_t     state, state_nxt;
  logic [RC_W-1:0]  row_cnt, row_cnt_nxt;
  logic [CNT_W-1:0] tag_cnt;
  logic [TAG_W-1:0] tag_head;
  logic             tags_empty, tags_full;
  logic             rdy, fire, w_fire, i_fire;
  logic             retire, pop;

  assign tags_empty = (tag_cnt == '0);
  assign tags_full  = (tag_cnt == CNT_W'(TAG_DEPTH));

  // Weights may only change once nothing computed with the old ones is pending.
  assign rdy = sb_weight ? (sa_fifo_has_space & tags_empty & ~wb_valid)
                         : (sa_fifo_has_space & (state == W_READY) & ~tags_full);

  assign sb_ready  = rdy;
  assign veg_ready = rdy;
  assign fire      = sb_valid & veg_valid & rdy;
  assign w_fire    = fire & sb_weight;
  assign i_fire    = fire & ~sb_weight;

  // Issue stage: strobes are combinational, operand data passes straight through
  assign sa_weight_en         = w_fire;
  assign sa_input_en          = i_fire;
  assign sa_partial_en        = i_fire;
  assign sa_array_in          = veg_vs1;
  assign sa_array_in_partials = veg_vs2;

  assign sa_output_ready = ~wb_valid | wb_output_ready;
  assign retire          = sa_out_valid & sa_output_ready;
  assign pop             = retire & ~tags_empty;

  assign weights_loaded = (state == W_READY);
  assign busy           = ~tags_empty | wb_valid;

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    if (w_fire) begin
      if (state == W_READY) begin
        // A new weight row in W_READY starts a fresh load sequence.
        if (ARRAY_ROWS == 1) begin
          state_nxt   = W_READY;
          row_cnt_nxt = '0;
        end else begin
          state_nxt   = W_LOAD;
          row_cnt_nxt = RC_W'(1);
        end
      end else if (row_cnt == RC_W'(ARRAY_ROWS - 1)) begin
        state_nxt   = W_READY;
        row_cnt_nxt = '0;
      end else begin
        state_nxt   = W_LOAD;
        row_cnt_nxt = row_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= W_IDLE;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tag_cnt <= '0;
    end else begin
      case ({i_fire, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  sync_fifo #(
    .FIFODEPTH (TAG_DEPTH),
    .DATAWIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (CLK),
    .n_rst (nRST),
    .wen   (i_fire),
    .ren   (pop),
    .wdata (sb_vdst),
    .rdata (tag_head)
  );

  // Writeback stage: one register slot, refilled in the same cycle it drains
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid      <= 1'b0;
      wb_psum       <= '0;
      wb_wbdst      <= '0;
      tag_underflow <= 1'b0;
    end else begin
      if (pop) begin
        wb_valid <= 1'b1;
        wb_psum  <= sa_array_output;
        wb_wbdst <= tag_head;
      end else if (wb_output_ready) begin
        wb_valid <= 1'b0;
      end
      if (retire & tags_empty) tag_underflow <= 1'b1;
    end
  end

`ifdef GSAU_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (i_fire) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (sb_valid & veg_valid & ~rdy) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
